sar_logic_param: RTL and testbench
==================================

// Module: sar_logic_param
// PURPOSE
//   Parametrised successive-approximation register controller for the SAR ADC.
//   Drives the DAC trial word q bit by bit from MSB to LSB and samples the comparator once per bit.
//   Supports configurable width, per-bit settle time, comparator polarity and abort.
//   Publishes the result on dout with a one-cycle done pulse.
//   Sits between the comparator and the capacitive DAC and replaces the fixed 6-bit controller.
// PARAMETERS
//   N         6   resolution in bits (2..16)
//   SETTLE    0   extra DAC settle cycles per bit (0..15); each bit takes SETTLE+1 cycles
//   COMP_POL  1   1: comp=1 means Vin >= DAC (keep bit); 0: comp is inverted
//   CW        localparam = $clog2(N+1), width of count
// PORTS
//   clk    in   1    single system clock, rising edge
//   rest   in   1    asynchronous active-high reset
//   ena    in   1    start request, sampled only in IDLE
//   abort  in   1    synchronous abort; returns to IDLE without done
//   comp   in   1    comparator decision for the current trial word
//   q      out  N    DAC trial word
//   dout   out  N    last completed conversion result
//   count  out  CW   number of bits resolved in the current conversion (0..N)
//   busy   out  1    conversion in progress
//   done   out  1    one-cycle pulse; dout is valid and new
// BEHAVIOUR
//   Reset (rest=1, async): q=0, dout=0, count=0, busy=0, done=0, state=IDLE, settle counter=0.
//   kept = comp ^ ~COMP_POL. Bit index k runs N-1..0.
//   States are IDLE, SETTLE and DECIDE.
//   IDLE: busy=0, q holds 0. At an edge with ena=1 and abort=0:
//     - q <= 1<<(N-1), k <= N-1, count <= 0, busy <= 1, timer <= SETTLE.
//     - Next state is SETTLE if SETTLE>0, else DECIDE.
//   SETTLE: timer decrements once per edge; when it reaches 0 the next state is DECIDE.
//   DECIDE: one edge.
//     - q[k] <= kept and count <= count+1.
//     - If k>0: q[k-1] <= 1, k <= k-1, timer reload, back to SETTLE (or stay in DECIDE if SETTLE=0).
//     - If k==0: dout <= final word (q with q[0]=kept), done <= 1, busy <= 0, q <= 0, IDLE.
//   Latency: start is edge E0; done is high in the cycle after edge E0 + N*(SETTLE+1).
//   done is a single-cycle pulse. dout holds its value until the next completion, including across abort.
//   ena while busy is ignored; no queuing. Earliest restart is at the edge after the done edge.
//     Back-to-back conversions therefore cost N*(SETTLE+1)+1 cycles.
//   abort=1 at any edge while busy: q<=0, count<=0, busy<=0, IDLE, no done, dout unchanged.
//     abort takes priority over DECIDE on the same edge. abort in IDLE has no effect and blocks ena.
//   comp is sampled only on DECIDE edges and ignored otherwise.
//     The comparator path must be stable at least SETTLE+1 cycles after each q change.
//   rest mid-conversion: immediate return to the reset values; dout is cleared to 0.
//   All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   sar_defs.vh: state encodings (ST_IDLE, ST_SETTLE, ST_DECIDE) and the CW computation macro.
//     Shared with the DAC sequencer.
//   Sub-module sar_settle_timer: 4-bit loadable down-counter.
//     Inputs load and reload value; output zero flag.
//     Instantiated once and tied off when SETTLE=0.
//   Top level holds the FSM, the bit-index register k, q, dout, count and done.
// TESTING
//   Comparator model: comp = (Vin >= q) ^ ~COMP_POL.
//   1. N=6, SETTLE=0, Vin=0x2B, pulse ena
//      -> q goes 0x20,0x30,0x28,0x2C,0x2A,0x2B; dout=0x2B; done 6 edges after start; count ends at 6.
//   2. Vin=0x00 and Vin=0x3F -> dout=0x00 and dout=0x3F; each run takes 6 edges.
//   3. SETTLE=2, Vin=0x15 -> q holds each trial for 3 cycles; done 18 edges after start; dout=0x15.
//   4. Hold ena high through the conversion -> second start only at the edge after done; no lost or extra done.
//   5. Previous dout=0x2B, start Vin=0x10, abort when count=3
//      -> busy=0 next cycle, q=0, no done, dout stays 0x2B.
//   6. Assert rest asynchronously mid-conversion (between edges)
//      -> all outputs 0 immediately.
//      Repeat with COMP_POL=0 and inverted comp -> results identical to scenario 1.

Source files
------------

// File: rtl/sar_logic_param_pkg.sv
// Shared types and sizing helpers for the SAR controller and its settle timer.
package sar_logic_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2
  } sar_state_e;

  localparam int unsigned TIMER_W = 4;

  function automatic int unsigned sar_cw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sar_logic_param_settle_timer.sv
// Loadable down-counter that paces DAC settling; o_zero_c flags expiry.
module sar_logic_param_settle_timer
  import sar_logic_param_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_rest,
  input  logic         i_load,
  input  logic [W-1:0] i_reload,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_reload;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sar_logic_param.sv
// Successive-approximation controller: walks the DAC trial word MSB to LSB,
// keeping or clearing each bit from the comparator, and publishes the result.
module sar_logic_param
  import sar_logic_param_pkg::*;
#(
  parameter  int unsigned N        = 6,
  parameter  int unsigned SETTLE   = 0,
  parameter  int unsigned COMP_POL = 1,
  localparam int unsigned CW       = sar_cw(N)
) (
  input  logic          i_clk,
  input  logic          i_rest,
  input  logic          i_ena,
  input  logic          i_abort,
  input  logic          i_comp,
  output logic [N-1:0]  o_q,
  output logic [N-1:0]  o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned KW         = $clog2(N);
  localparam logic        POL        = 1'(COMP_POL);
  localparam logic        USE_TIMER  = (SETTLE > 0);
  localparam int unsigned RELOAD     = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam sar_state_e  ST_PER_BIT = (SETTLE > 0) ? ST_SETTLE : ST_DECIDE;

  sar_state_e    r_state, w_state_nxt;
  logic [N-1:0]  r_q, w_q_nxt;
  logic [N-1:0]  r_dout, w_dout_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          w_timer_load;
  logic          w_timer_zero;
  logic          w_kept;

  assign w_kept = i_comp ^ ~POL;

  // Loaded with SETTLE-1 so that the zero flag lands exactly SETTLE cycles later.
  sar_logic_param_settle_timer #(.W(TIMER_W)) u_settle_timer (
    .i_clk    (i_clk),
    .i_rest   (i_rest),
    .i_load   (w_timer_load & USE_TIMER),
    .i_reload (TIMER_W'(RELOAD)),
    .o_zero_c (w_timer_zero)
  );

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_dout  <= '0;
      r_count <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_dout  <= w_dout_nxt;
      r_count <= w_count_nxt;
      r_k     <= w_k_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_dout_nxt   = r_dout;
    w_count_nxt  = r_count;
    w_k_nxt      = r_k;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_timer_load = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_ena && !i_abort) begin
          w_q_nxt        = '0;
          w_q_nxt[N-1]   = 1'b1;
          w_k_nxt        = KW'(N - 1);
          w_count_nxt    = '0;
          w_busy_nxt     = 1'b1;
          w_timer_load   = 1'b1;
          w_state_nxt    = ST_PER_BIT;
        end
      end
      ST_SETTLE: begin
        if (w_timer_zero) begin
          w_state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        w_q_nxt[r_k] = w_kept;
        w_count_nxt  = r_count + CW'(1);
        if (r_k != '0) begin
          w_q_nxt[r_k - KW'(1)] = 1'b1;
          w_k_nxt               = r_k - KW'(1);
          w_timer_load          = 1'b1;
          w_state_nxt           = ST_PER_BIT;
        end else begin
          w_dout_nxt  = w_q_nxt;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_q_nxt     = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort wins over any in-flight decision and never produces a result.
    if (i_abort && r_state != ST_IDLE) begin
      w_state_nxt  = ST_IDLE;
      w_q_nxt      = '0;
      w_count_nxt  = '0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_dout_nxt   = r_dout;
      w_timer_load = 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_dout  = r_dout;
  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_sar_logic_param.sv
// Bench for sar_logic_param: three configurations driven by an ideal comparator
// and checked against a binary-search reference computed from the input voltage.
module tb_sar_logic_param;

  localparam int NB = 6;

  logic       clk = 1'b0;
  logic       rest;
  logic       abort;
  logic [7:0] vin;
  logic       ena_a  [3];
  logic       comp_a [3];
  logic [5:0] q_a    [3];
  logic [5:0] dout_a [3];
  logic [2:0] cnt_a  [3];
  logic       busy_a [3];
  logic       done_a [3];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  // Ideal comparator; instance 2 sees the inverted polarity.
  assign comp_a[0] =  ({2'b00, q_a[0]} <= vin);
  assign comp_a[1] =  ({2'b00, q_a[1]} <= vin);
  assign comp_a[2] = ~({2'b00, q_a[2]} <= vin);

  sar_logic_param #(.N(6), .SETTLE(0), .COMP_POL(1)) u_dut0 (
    .i_clk(clk), .i_rest(rest), .i_ena(ena_a[0]), .i_abort(abort), .i_comp(comp_a[0]),
    .o_q(q_a[0]), .o_dout(dout_a[0]), .o_count(cnt_a[0]), .o_busy(busy_a[0]), .o_done(done_a[0]));
  sar_logic_param #(.N(6), .SETTLE(2), .COMP_POL(1)) u_dut1 (
    .i_clk(clk), .i_rest(rest), .i_ena(ena_a[1]), .i_abort(abort), .i_comp(comp_a[1]),
    .o_q(q_a[1]), .o_dout(dout_a[1]), .o_count(cnt_a[1]), .o_busy(busy_a[1]), .o_done(done_a[1]));
  sar_logic_param #(.N(6), .SETTLE(0), .COMP_POL(0)) u_dut2 (
    .i_clk(clk), .i_rest(rest), .i_ena(ena_a[2]), .i_abort(abort), .i_comp(comp_a[2]),
    .o_q(q_a[2]), .o_dout(dout_a[2]), .o_count(cnt_a[2]), .o_busy(busy_a[2]), .o_done(done_a[2]));

  typedef struct {
    int dut;
    int vin;
    int exp_dout;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int settle_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  // Trial word j of a binary search for v: resolved upper bits plus the probe bit.
  function automatic int trial(input int v, input int j);
    int hi_mask;
    hi_mask = ~((1 << (NB - j)) - 1);
    return ((v & hi_mask) | (1 << (NB - 1 - j))) & 63;
  endfunction

  task automatic run_conv(input int d, input int v, input int exp_dout);
    int s;
    int lat;
    s   = settle_of(d);
    lat = NB * (s + 1);
    vin = 8'(v);
    @(negedge clk);
    ena_a[d] = 1'b1;
    @(negedge clk);
    ena_a[d] = 1'b0;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c < lat) begin
        chk($sformatf("d%0d v%0d q c%0d", d, v, c), int'(q_a[d]), trial(v, c / (s + 1)));
        chk($sformatf("d%0d v%0d cnt c%0d", d, v, c), int'(cnt_a[d]), c / (s + 1));
        chk($sformatf("d%0d v%0d busy c%0d", d, v, c), int'(busy_a[d]), 1);
        chk($sformatf("d%0d v%0d done c%0d", d, v, c), int'(done_a[d]), 0);
      end else if (c == lat) begin
        chk($sformatf("d%0d v%0d done_end", d, v), int'(done_a[d]), 1);
        chk($sformatf("d%0d v%0d dout", d, v), int'(dout_a[d]), exp_dout);
        chk($sformatf("d%0d v%0d busy_end", d, v), int'(busy_a[d]), 0);
        chk($sformatf("d%0d v%0d q_end", d, v), int'(q_a[d]), 0);
        chk($sformatf("d%0d v%0d cnt_end", d, v), int'(cnt_a[d]), NB);
      end else begin
        chk($sformatf("d%0d v%0d done_pulse", d, v), int'(done_a[d]), 0);
      end
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   nd;
    int   f1;
    int   f2;

    rest  = 1'b1;
    abort = 1'b0;
    vin   = 8'd0;
    for (int i = 0; i < 3; i++) ena_a[i] = 1'b0;

    vecs.push_back('{0, 'h2B, 'h2B});
    vecs.push_back('{0, 'h00, 'h00});
    vecs.push_back('{0, 'h3F, 'h3F});
    vecs.push_back('{1, 'h15, 'h15});
    vecs.push_back('{1, 'h3F, 'h3F});
    vecs.push_back('{2, 'h2B, 'h2B});
    vecs.push_back('{2, 'h00, 'h00});
    vecs.push_back('{2, 'h3F, 'h3F});

    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst q%0d", i), int'(q_a[i]), 0);
      chk($sformatf("rst dout%0d", i), int'(dout_a[i]), 0);
      chk($sformatf("rst cnt%0d", i), int'(cnt_a[i]), 0);
      chk($sformatf("rst busy%0d", i), int'(busy_a[i]), 0);
      chk($sformatf("rst done%0d", i), int'(done_a[i]), 0);
    end
    @(negedge clk);
    rest = 1'b0;

    foreach (vecs[i]) run_conv(vecs[i].dut, vecs[i].vin, vecs[i].exp_dout);

    for (int i = 0; i < 24; i++) begin
      int d;
      int v;
      d = int'($urandom_range(0, 2));
      v = int'($urandom_range(0, 63));
      run_conv(d, v, v);
    end

    // ena held high: restart only on the edge after done, one done per conversion
    vin = 8'h2B;
    @(negedge clk);
    ena_a[0] = 1'b1;
    nd = 0; f1 = -1; f2 = -1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (done_a[0]) begin
        nd++;
        if (f1 < 0) f1 = c; else f2 = c;
      end
      if (c == 6) chk("hold busy_gap", int'(busy_a[0]), 0);
      if (c == 7) begin
        chk("hold restart busy", int'(busy_a[0]), 1);
        chk("hold restart q", int'(q_a[0]), 'h20);
      end
      if (c == 13) ena_a[0] = 1'b0;
      if (c == 14) chk("hold idle", int'(busy_a[0]), 0);
    end
    chk("hold ndone", nd, 2);
    chk("hold first", f1, 6);
    chk("hold second", f2, 13);
    chk("hold dout", int'(dout_a[0]), 'h2B);

    // abort at count 3 leaves the previous result untouched
    vin = 8'h10;
    @(negedge clk);
    ena_a[0] = 1'b1;
    @(negedge clk);
    ena_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre cnt", int'(cnt_a[0]), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(busy_a[0]), 0);
    chk("abort q", int'(q_a[0]), 0);
    chk("abort cnt", int'(cnt_a[0]), 0);
    chk("abort done", int'(done_a[0]), 0);
    chk("abort dout", int'(dout_a[0]), 'h2B);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a[0]) nd++;
    end
    chk("abort no_done", nd, 0);
    chk("abort dout_hold", int'(dout_a[0]), 'h2B);

    // abort in IDLE blocks a start request
    @(negedge clk);
    abort = 1'b1;
    ena_a[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ena_a[0] = 1'b0;
    chk("idle abort busy", int'(busy_a[0]), 0);
    chk("idle abort q", int'(q_a[0]), 0);
    run_conv(0, 'h10, 'h10);

    // asynchronous reset between edges mid-conversion
    vin = 8'h2B;
    @(negedge clk);
    ena_a[0] = 1'b1;
    @(negedge clk);
    ena_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rest = 1'b1;
    #1;
    chk("arst q", int'(q_a[0]), 0);
    chk("arst dout", int'(dout_a[0]), 0);
    chk("arst cnt", int'(cnt_a[0]), 0);
    chk("arst busy", int'(busy_a[0]), 0);
    chk("arst done", int'(done_a[0]), 0);
    @(negedge clk);
    rest = 1'b0;
    run_conv(0, 'h2B, 'h2B);
    run_conv(2, 'h2B, 'h2B);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
